// File: rtl/i2c_pkg.sv
// i2c_pkg: command encodings, FSM state codes and quarter-phase type for i2c_cmd_master
package i2c_pkg;
   localparam logic [1:0] I2C_START = 2'd0;
   localparam logic [1:0] I2C_STOP  = 2'd1;
   localparam logic [1:0] I2C_WRITE = 2'd2;
   localparam logic [1:0] I2C_READ  = 2'd3;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_RSTART = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd3;
   localparam logic [2:0] S_BIT_TX = 3'd4;
   localparam logic [2:0] S_BIT_RX = 3'd5;
   localparam logic [2:0] S_ACK_RX = 3'd6;
   localparam logic [2:0] S_ACK_TX = 3'd7;
   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} qphase_t;
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: quarter-SCL-period pulse generator that holds still while frozen
module i2c_quarter_tick #(
   parameter int CLK_DIV = 125
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic freeze,
   output logic q
);
   localparam int W = $clog2(CLK_DIV);
   logic [W-1:0] cnt;
   assign q = !freeze && cnt == W'(CLK_DIV - 1);
   always_ff @(posedge clock)
      if (reset || clr) cnt <= '0;
      else if (!freeze) cnt <= q ? '0 : cnt + 1'b1;
endmodule

// File: rtl/i2c_cmd_master.sv
// i2c_cmd_master: command-driven I2C master with repeated start, clock stretching and timeout
module i2c_cmd_master import i2c_pkg::*; #(
   parameter int CLK_DIV     = 125,
   parameter int STRETCH_MAX = 4096
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic       cmd_nack,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       done,
   output logic       ack_err,
   output logic       seq_err,
   output logic       timeout_err,
   output logic       bus_owned,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe
);
   localparam int SW = $clog2(STRETCH_MAX + 1);
   logic [2:0] st;
   qphase_t ph;
   logic [2:0] bit_cnt;
   logic [7:0] sr;
   logic nack_r, sda_hold, q, scl_drv, sda_drv, freeze, tmo;
   logic [SW-1:0] s_cnt;
   always_comb begin
      scl_drv = ph == Q0 || ph == Q3;
      sda_drv = 1'b0;
      case (st)
         S_IDLE: begin
            scl_drv = bus_owned;
            sda_drv = bus_owned && sda_hold;
         end
         S_START, S_RSTART: begin
            scl_drv = ph == Q3 || (ph == Q0 && st == S_RSTART);
            sda_drv = ph[1];
         end
         S_STOP: begin
            scl_drv = ph == Q0;
            sda_drv = ph != Q3;
         end
         S_BIT_TX: sda_drv = !sr[7];
         S_ACK_TX: sda_drv = !nack_r;
         default: ;
      endcase
   end
   assign scl_oe    = scl_drv;
   assign sda_oe    = sda_drv;
   assign cmd_ready = st == S_IDLE;
   // a released SCL still read low means the slave is stretching
   assign freeze = st != S_IDLE && !scl_drv && !scl_in;
   assign tmo    = freeze && s_cnt == SW'(STRETCH_MAX - 1);
   i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clock (clock),
      .reset (reset),
      .clr   (st == S_IDLE),
      .freeze(freeze),
      .q     (q)
   );
   always_ff @(posedge clock)
      if (reset) s_cnt <= '0;
      else s_cnt <= freeze ? s_cnt + 1'b1 : '0;
   always_ff @(posedge clock) begin
      if (reset) begin
         st          <= S_IDLE;
         ph          <= Q0;
         bit_cnt     <= '0;
         sr          <= '0;
         nack_r      <= 1'b0;
         sda_hold    <= 1'b0;
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         done        <= 1'b0;
         ack_err     <= 1'b0;
         seq_err     <= 1'b0;
         timeout_err <= 1'b0;
         bus_owned   <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         if (st != S_IDLE) sda_hold <= sda_drv;
         if (st == S_IDLE) begin
            if (cmd_valid) begin
               nack_r  <= cmd_nack;
               sr      <= wr_data;
               ph      <= Q0;
               bit_cnt <= '0;
               if (cmd_op == I2C_START) begin
                  st          <= bus_owned ? S_RSTART : S_START;
                  seq_err     <= 1'b0;
                  timeout_err <= 1'b0;
               end else if (!bus_owned) begin
                  seq_err <= 1'b1;
                  done    <= 1'b1;
               end else st <= cmd_op == I2C_STOP ? S_STOP : cmd_op == I2C_WRITE ? S_BIT_TX : S_BIT_RX;
            end
         end else if (tmo) begin
            st          <= S_IDLE;
            bus_owned   <= 1'b0;
            timeout_err <= 1'b1;
            done        <= 1'b1;
         end else if (q) begin
            ph <= qphase_t'(ph + 2'd1);
            if (ph == Q2 && st == S_BIT_RX) sr <= {sr[6:0], sda_in};
            if (ph == Q2 && st == S_ACK_RX) sr[0] <= sda_in;
            if (ph == Q3) begin
               bit_cnt <= bit_cnt + 3'd1;
               case (st)
                  S_START, S_RSTART: begin
                     st        <= S_IDLE;
                     bus_owned <= 1'b1;
                     done      <= 1'b1;
                  end
                  S_STOP: begin
                     st        <= S_IDLE;
                     bus_owned <= 1'b0;
                     done      <= 1'b1;
                  end
                  S_BIT_TX: begin
                     sr <= {sr[6:0], 1'b0};
                     if (bit_cnt == 3'd7) st <= S_ACK_RX;
                  end
                  S_BIT_RX: if (bit_cnt == 3'd7) st <= S_ACK_TX;
                  S_ACK_RX: begin
                     st      <= S_IDLE;
                     ack_err <= sr[0];
                     done    <= 1'b1;
                  end
                  S_ACK_TX: begin
                     st       <= S_IDLE;
                     rd_data  <= sr;
                     rd_valid <= 1'b1;
                     done     <= 1'b1;
                  end
                  default: st <= S_IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_i2c_cmd_master.sv
// tb_i2c_cmd_master: directed and randomized commands against a pad-level I2C slave model
module tb_i2c_cmd_master;
   import i2c_pkg::*;
   localparam int CLK_DIV     = 4;
   localparam int STRETCH_MAX = 64;
   localparam int QL          = 4 * CLK_DIV;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic cmd_valid = 1'b0, cmd_nack = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [7:0] wr_data = 8'd0;
   logic cmd_ready, rd_valid, done, ack_err, seq_err, timeout_err, bus_owned, scl_oe, sda_oe;
   logic [7:0] rd_data;
   logic scl_in, sda_in, s_drv;
   logic s_tx = 1'b0, s_nack = 1'b0, s_rose = 1'b0, ack_oe_seen = 1'b0;
   logic [7:0] s_byte = 8'd0, s_rx = 8'd0, s_last_rx = 8'd0;
   logic scl_p = 1'b1, sda_p = 1'b1, scl_oe_p = 1'b0, sda_oe_p = 1'b0;
   int s_idx = 0, cyc = 0, hold_until = 0;
   int n_start = 0, n_stop = 0, n_done = 0, n_toggle = 0;
   int n_chk = 0, n_pass = 0;
   logic m_owned = 1'b0, m_ack = 1'b0, m_seq = 1'b0, m_tmo = 1'b0;
   always #5 clock = ~clock;
   i2c_cmd_master #(.CLK_DIV(CLK_DIV), .STRETCH_MAX(STRETCH_MAX)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_nack(cmd_nack), .wr_data(wr_data), .rd_data(rd_data),
      .rd_valid(rd_valid), .done(done), .ack_err(ack_err), .seq_err(seq_err),
      .timeout_err(timeout_err), .bus_owned(bus_owned), .scl_in(scl_in), .sda_in(sda_in),
      .scl_oe(scl_oe), .sda_oe(sda_oe)
   );
   // open-drain bus: slave transmits data in tx mode, acks bit 8 in rx mode
   assign s_drv  = s_tx ? (s_idx < 8 && !s_byte[3'(7 - s_idx)]) : (s_idx == 8 && !s_nack);
   assign scl_in = !(scl_oe || cyc < hold_until);
   assign sda_in = !(sda_oe || s_drv);
   always @(posedge clock) begin
      cyc      <= cyc + 1;
      scl_p    <= scl_in;
      sda_p    <= sda_in;
      scl_oe_p <= scl_oe;
      sda_oe_p <= sda_oe;
      if ({scl_oe, sda_oe} != {scl_oe_p, sda_oe_p}) n_toggle <= n_toggle + 1;
      if (done) n_done <= n_done + 1;
      if (reset) begin
         s_idx  <= 0;
         s_rose <= 1'b0;
      end else if (scl_p && scl_in && sda_p && !sda_in) begin
         n_start <= n_start + 1;
         s_idx   <= 0;
         s_rose  <= 1'b0;
      end else if (scl_p && scl_in && !sda_p && sda_in) begin
         n_stop <= n_stop + 1;
         s_idx  <= 0;
         s_rose <= 1'b0;
      end else if (!scl_p && scl_in) begin
         s_rose <= 1'b1;
         if (s_idx < 8) s_rx <= {s_rx[6:0], sda_in};
         if (s_idx == 7) s_last_rx <= {s_rx[6:0], sda_in};
         if (s_idx == 8) ack_oe_seen <= sda_oe;
      end else if (scl_p && !scl_in && s_rose) begin
         s_rose <= 1'b0;
         s_idx  <= s_idx == 8 ? 0 : s_idx + 1;
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask
   task automatic issue(input logic [1:0] op, input logic nk, input logic [7:0] d, output int lat);
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_nack  = nk;
      wr_data   = d;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      wr_data   = ~d;
      lat = 0;
      while (!done && lat < 3000) begin
         @(posedge clock);
         #1;
         lat++;
      end
      chk("done_seen", done, 1);
   endtask
   task automatic stretch(input int n);
      for (int i = 0; i < 1000 && s_idx != 3; i++) @(posedge clock);
      hold_until = cyc + n;
   endtask
   task automatic do_cmd(input logic [1:0] op, input logic nk, input logic [7:0] d,
                         input logic [7:0] sb, input logic sn, input int hmax);
      int lat, el;
      logic legal;
      legal  = op == I2C_START || m_owned;
      s_tx   = op == I2C_READ && m_owned;
      s_byte = sb;
      s_nack = sn;
      el = !legal ? 0 : (op == I2C_START || op == I2C_STOP) ? QL : 9 * QL;
      issue(op, nk, d, lat);
      if (hmax == 0) chk("latency", lat, el);
      else chk("latency_stretch", lat > el && lat <= el + hmax, 1);
      if (!legal) m_seq = 1'b1;
      else if (op == I2C_START) begin
         m_seq   = 1'b0;
         m_tmo   = 1'b0;
         m_owned = 1'b1;
      end else if (op == I2C_STOP) m_owned = 1'b0;
      else if (op == I2C_WRITE) m_ack = sn;
      chk("bus_owned", bus_owned, m_owned);
      chk("seq_err", seq_err, m_seq);
      chk("ack_err", ack_err, m_ack);
      chk("timeout_err", timeout_err, m_tmo);
      chk("rd_valid", rd_valid, legal && op == I2C_READ);
      chk("scl_idle", scl_oe, m_owned);
      if (legal && op == I2C_READ) begin
         chk("rd_data", rd_data, sb);
         chk("ack_drive", ack_oe_seen, !nk);
      end
      if (legal && op == I2C_WRITE) chk("slave_rx", s_last_rx, d);
      @(posedge clock);
      #1;
      chk("pulse_width", {done, rd_valid}, 0);
   endtask
   initial begin
      #900000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end
   initial begin
      int lat, d0, t0, s0, p0, nops;
      logic [1:0] op;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_outs", {cmd_ready, scl_oe, sda_oe, rd_valid, done, ack_err, seq_err, timeout_err,
                         bus_owned, rd_data}, 32'h10000);
      @(negedge clock);
      reset = 1'b0;
      d0 = n_done;
      do_cmd(I2C_START, 0, 0, 0, 0, 0);
      do_cmd(I2C_WRITE, 0, 8'h34, 0, 0, 0);
      do_cmd(I2C_STOP, 0, 0, 0, 0, 0);
      chk("done_pulses", n_done - d0, 3);
      do_cmd(I2C_START, 0, 0, 0, 0, 0);
      do_cmd(I2C_WRITE, 0, 8'hA5, 0, 1, 0);
      do_cmd(I2C_STOP, 0, 0, 0, 0, 0);
      chk("stop_release", {scl_oe, sda_oe}, 0);
      do_cmd(I2C_START, 0, 0, 0, 0, 0);
      do_cmd(I2C_WRITE, 0, 8'h35, 0, 0, 0);
      do_cmd(I2C_READ, 0, 0, 8'h5A, 0, 0);
      do_cmd(I2C_READ, 1, 0, 8'hC3, 0, 0);
      do_cmd(I2C_STOP, 0, 0, 0, 0, 0);
      s0 = n_start;
      p0 = n_stop;
      do_cmd(I2C_START, 0, 0, 0, 0, 0);
      do_cmd(I2C_START, 0, 0, 0, 0, 0);
      chk("rstart_starts", n_start - s0, 2);
      chk("rstart_stops", n_stop - p0, 0);
      do_cmd(I2C_STOP, 0, 0, 0, 0, 0);
      do_cmd(I2C_START, 0, 0, 0, 0, 0);
      fork
         do_cmd(I2C_WRITE, 0, 8'h96, 0, 0, 20);
         stretch(20);
      join
      do_cmd(I2C_STOP, 0, 0, 0, 0, 0);
      do_cmd(I2C_START, 0, 0, 0, 0, 0);
      fork
         issue(I2C_WRITE, 0, 8'h0F, lat);
         stretch(100);
      join
      m_owned = 1'b0;
      m_tmo   = 1'b1;
      chk("tmo_early", lat < 9 * QL, 1);
      chk("tmo_err", timeout_err, 1);
      chk("tmo_release", {scl_oe, sda_oe, bus_owned}, 0);
      for (int i = 0; i < 200 && cyc < hold_until + 2; i++) @(posedge clock);
      do_cmd(I2C_START, 0, 0, 0, 0, 0);
      do_cmd(I2C_STOP, 0, 0, 0, 0, 0);
      t0 = n_toggle;
      do_cmd(I2C_WRITE, 0, 8'h55, 0, 0, 0);
      do_cmd(I2C_READ, 0, 0, 8'h11, 0, 0);
      do_cmd(I2C_STOP, 0, 0, 0, 0, 0);
      chk("idle_no_toggle", n_toggle - t0, 0);
      do_cmd(I2C_START, 0, 0, 0, 0, 0);
      do_cmd(I2C_WRITE, 0, 8'h12, 0, 1, 0);
      s_tx   = 1'b1;
      s_byte = 8'hE7;
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_op    = I2C_READ;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      repeat (60) @(posedge clock);
      #1;
      chk("busy_mid_read", cmd_ready, 0);
      @(negedge clock);
      reset = 1'b1;
      s_tx  = 1'b0;
      @(posedge clock);
      #1;
      chk("reset_mid_read", {cmd_ready, scl_oe, sda_oe, rd_valid, done, ack_err, seq_err, timeout_err,
                             bus_owned, rd_data}, 32'h10000);
      @(negedge clock);
      reset = 1'b0;
      {m_owned, m_ack, m_seq, m_tmo} = 4'b0;
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(3) == 0) do_cmd(I2C_WRITE, 0, 8'($urandom), 0, 0, 0);
         do_cmd(I2C_START, 0, 0, 0, 0, 0);
         nops = $urandom_range(1, 4);
         for (int k = 0; k < nops; k++) begin
            if ($urandom_range(5) == 0) do_cmd(I2C_START, 0, 0, 0, 0, 0);
            op = $urandom_range(1) != 0 ? I2C_WRITE : I2C_READ;
            do_cmd(op, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0);
         end
         do_cmd(I2C_STOP, 0, 0, 0, 0, 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
